// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: opcodes, load/store funct3 encodings,
// memory-stage FSM states and access-size helpers.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_t;

    // Byte-enable pattern for an access of 1/2/4/8 bytes at lane 0.
    function automatic logic [7:0] size_strobe(input logic [1:0] size);
        case (size)
            2'd0:    size_strobe = 8'h01;
            2'd1:    size_strobe = 8'h03;
            2'd2:    size_strobe = 8'h0F;
            default: size_strobe = 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: shifts the addressed bytes of a doubleword down to
// bit 0 and sign- or zero-extends according to funct3.
module load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_LWU:  data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage with a single-outstanding data-memory port.
// Optional MEM_MISALIGN_CHECK_EN: misaligned accesses retire as faults without a request.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   ALUresult,
    input  logic [XLEN-1:0]   valB,
    input  logic [4:0]        rd,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [3:0]        num_bytes,
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       instruction,
    input  logic              noop,
    output logic              hit,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic [XLEN-1:0]   dreq_addr,
    output logic              dreq_we,
    output logic [XLEN-1:0]   dreq_wdata,
    output logic [XLEN/8-1:0] dreq_wstrb,
    input  logic              drsp_valid,
    input  logic [XLEN-1:0]   drsp_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   wb_pc,
    output logic [31:0]       wb_instruction,
    output logic              wb_fault
);

    mem_state_t      state, state_nx;
    logic            is_mem;
    logic            misalign_fault;
    logic [2:0]      low_mask;
    logic [XLEN-1:0] eff_addr;
    logic [XLEN-1:0] load_data;
    logic [2:0]      lat_f3;
    logic [4:0]      lat_rd;
    logic [XLEN-1:0] lat_pc;
    logic [31:0]     lat_instr;
    logic            unused_num_bytes;

    // Access size comes from funct3; the redundant byte count is not needed.
    assign unused_num_bytes = ^num_bytes;

    assign is_mem   = !noop && (opcode == OPC_LOAD || opcode == OPC_STORE);
    assign low_mask = align_mask(funct3[1:0]);
    assign eff_addr = {ALUresult[XLEN-1:3], ALUresult[2:0] & ~low_mask};

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_fault = is_mem && |(ALUresult[2:0] & low_mask);
`else
    assign misalign_fault = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        hit        = 1'b0;
        dreq_valid = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem && !misalign_fault) state_nx = REQ;
                else                           hit      = 1'b1;
            end
            REQ: begin
                dreq_valid = 1'b1;
                if (dreq_ready) state_nx = WAIT;
            end
            WAIT: begin
                if (drsp_valid) begin
                    hit      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Request fields are captured once in IDLE and stay stable through REQ/WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dreq_addr  <= '0;
            dreq_we    <= 1'b0;
            dreq_wdata <= '0;
            dreq_wstrb <= '0;
            lat_f3     <= '0;
            lat_rd     <= '0;
            lat_pc     <= '0;
            lat_instr  <= '0;
        end else if (state == IDLE && is_mem && !misalign_fault) begin
            dreq_addr  <= eff_addr;
            dreq_we    <= (opcode == OPC_STORE);
            dreq_wdata <= valB << {eff_addr[2:0], 3'b000};
            dreq_wstrb <= size_strobe(funct3[1:0]) << eff_addr[2:0];
            lat_f3     <= funct3;
            lat_rd     <= rd;
            lat_pc     <= pc;
            lat_instr  <= instruction;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (drsp_rdata),
        .lane   (dreq_addr[2:0]),
        .funct3 (lat_f3),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            wb_pc          <= '0;
            wb_instruction <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (state == IDLE && !noop && (!is_mem || misalign_fault)) begin
                wb_valid       <= 1'b1;
                wb_rd          <= (misalign_fault || opcode == OPC_BRANCH) ? 5'd0 : rd;
                wb_data        <= ALUresult;
                wb_pc          <= pc;
                wb_instruction <= instruction;
            end else if (state == WAIT && drsp_valid) begin
                wb_valid       <= 1'b1;
                wb_rd          <= dreq_we ? 5'd0 : lat_rd;
                wb_data        <= dreq_we ? '0 : load_data;
                wb_pc          <= lat_pc;
                wb_instruction <= lat_instr;
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 wb_fault <= 1'b0;
        else if (state == IDLE && !noop)            wb_fault <= misalign_fault;
        else if (state == WAIT && drsp_valid)       wb_fault <= 1'b0;
    end
`else
    assign wb_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected requests and
// write-backs; separate monitors pop and compare when the DUT presents them.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [63:0] ALUresult, valB, pc, dreq_addr, dreq_wdata, drsp_rdata;
    logic [63:0] wb_data, wb_pc;
    logic [4:0]  rd, wb_rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [3:0]  num_bytes;
    logic [31:0] instruction, wb_instruction;
    logic        noop, hit, dreq_valid, dreq_ready, dreq_we, drsp_valid;
    logic        wb_valid, wb_fault;
    logic [7:0]  dreq_wstrb;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
        bit          chk_data;
    } wb_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_exp_t;

    wb_exp_t  wbq[$];
    req_exp_t reqq[$];
    wb_exp_t  wb_e;
    req_exp_t req_e;
    int       errors = 0;
    int       checks = 0;
    logic [63:0] pc_ctr = 64'h8000_0000;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011;
    localparam logic [6:0] ALU  = 7'b0010011, BRANCH = 7'b1100011;

    mem_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .ALUresult(ALUresult), .valB(valB), .rd(rd),
        .opcode(opcode), .funct3(funct3), .num_bytes(num_bytes), .pc(pc),
        .instruction(instruction), .noop(noop), .hit(hit),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
        .dreq_we(dreq_we), .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
        .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
        .wb_instruction(wb_instruction), .wb_fault(wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid === 1'b1) begin
            if (wbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d expected no write-back", wb_rd);
            end else begin
                wb_e = wbq.pop_front();
                chk("wb_rd", 64'(wb_rd), 64'(wb_e.rd));
                chk("wb_pc", wb_pc, wb_e.pc);
                chk("wb_instruction", 64'(wb_instruction), 64'(wb_e.instr));
                chk("wb_fault", 64'(wb_fault), 64'(wb_e.fault));
                if (wb_e.chk_data) chk("wb_data", wb_data, wb_e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dreq_valid === 1'b1 && dreq_ready === 1'b1) begin
            if (reqq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: got request addr=0x%0h expected none", dreq_addr);
            end else begin
                req_e = reqq.pop_front();
                chk("req_addr", dreq_addr, req_e.addr);
                chk("req_we", 64'(dreq_we), 64'(req_e.we));
                chk("req_wdata", dreq_wdata, req_e.wdata);
                chk("req_wstrb", 64'(dreq_wstrb), 64'(req_e.wstrb));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [6:0] opc, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] vb,
                            input logic [4:0] r);
        pc_ctr      = pc_ctr + 64'd4;
        noop        = 1'b0;
        opcode      = opc;
        funct3      = f3;
        ALUresult   = addr;
        valB        = vb;
        rd          = r;
        num_bytes   = 4'd1 << f3[1:0];
        pc          = pc_ctr;
        instruction = {pc_ctr[19:0], r, opc};
    endtask

    task automatic bubble();
        noop   = 1'b1;
        opcode = 7'd0;
    endtask

    task automatic alu_op(input logic [6:0] opc, input logic [63:0] res,
                          input logic [4:0] r, input logic [4:0] exp_rd);
        wb_exp_t w;
        step();
        drive_op(opc, 3'd0, res, 64'd0, r);
        w = '{rd: exp_rd, data: res, pc: pc, instr: instruction, fault: 1'b0, chk_data: 1'b1};
        wbq.push_back(w);
        @(negedge clk);
        chk("alu_hit", 64'(hit), 64'd1);
        chk("alu_no_req", 64'(dreq_valid), 64'd0);
        step();
        bubble();
        @(negedge clk);
        chk("alu_latency", 64'(wb_valid), 64'd1);
    endtask

    task automatic mem_op(input logic [6:0] opc, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] vb,
                          input logic [4:0] r, input int unsigned stall,
                          input int unsigned waitc, input logic [63:0] rdata,
                          input logic [63:0] e_addr, input logic [7:0] e_strb,
                          input logic [63:0] e_wdata, input logic [63:0] e_data);
        wb_exp_t  w;
        req_exp_t q;
        logic     st;
        st = (opc == STORE);
        step();
        drive_op(opc, f3, addr, vb, r);
        q = '{addr: e_addr, we: st, wdata: e_wdata, wstrb: e_strb};
        reqq.push_back(q);
        w = '{rd: st ? 5'd0 : r, data: e_data, pc: pc, instr: instruction,
              fault: 1'b0, chk_data: !st};
        wbq.push_back(w);
        @(negedge clk);
        chk("mem_hit_idle", 64'(hit), 64'd0);
        chk("mem_idle_no_req", 64'(dreq_valid), 64'd0);
        for (int unsigned i = 0; i < stall; i++) begin
            step();
            dreq_ready = 1'b0;
            @(negedge clk);
            chk("stall_valid", 64'(dreq_valid), 64'd1);
            chk("stall_addr", dreq_addr, e_addr);
            chk("stall_wdata", dreq_wdata, e_wdata);
            chk("stall_wstrb", 64'(dreq_wstrb), 64'(e_strb));
            chk("stall_we", 64'(dreq_we), 64'(st));
            chk("stall_hit", 64'(hit), 64'd0);
        end
        step();
        dreq_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", 64'(dreq_valid), 64'd1);
        chk("req_hit", 64'(hit), 64'd0);
        for (int unsigned i = 0; i < waitc; i++) begin
            step();
            dreq_ready = 1'b0;
            @(negedge clk);
            chk("wait_valid", 64'(dreq_valid), 64'd0);
            chk("wait_hit", 64'(hit), 64'd0);
            chk("wait_wb", 64'(wb_valid), 64'd0);
        end
        step();
        dreq_ready = 1'b0;
        drsp_valid = 1'b1;
        drsp_rdata = rdata;
        @(negedge clk);
        chk("rsp_hit", 64'(hit), 64'd1);
        chk("rsp_wb_not_yet", 64'(wb_valid), 64'd0);
        step();
        drsp_valid = 1'b0;
        drsp_rdata = 64'hA5A5_5A5A_A5A5_5A5A;
        bubble();
        @(negedge clk);
        chk("mem_latency", 64'(wb_valid), 64'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        bubble();
        funct3 = '0; ALUresult = '0; valB = '0; rd = '0; pc = '0;
        instruction = '0; num_bytes = '0;
        dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst_dreq_we", 64'(dreq_we), 64'd0);
        chk("rst_dreq_wstrb", 64'(dreq_wstrb), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("bubble_hit", 64'(hit), 64'd1);

        alu_op(ALU, 64'h1234, 5'd5, 5'd5);
        alu_op(BRANCH, 64'h40, 5'd7, 5'd0);

        mem_op(LOAD, 3'b000, 64'h1003, 64'd0, 5'd10, 0, 0, 64'h0000_0000_8000_0000,
               64'h1003, 8'h08, 64'd0, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op(LOAD, 3'b100, 64'h1003, 64'd0, 5'd11, 0, 0, 64'h0000_0000_8000_0000,
               64'h1003, 8'h08, 64'd0, 64'h80);
        mem_op(STORE, 3'b001, 64'h2006, 64'hBEEF, 5'd3, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h2006, 8'hC0, 64'hBEEF_0000_0000_0000, 64'd0);
        mem_op(LOAD, 3'b010, 64'h3004, 64'd0, 5'd12, 3, 2, 64'h89AB_CDEF_0000_0000,
               64'h3004, 8'hF0, 64'd0, 64'hFFFF_FFFF_89AB_CDEF);
        mem_op(LOAD, 3'b110, 64'h3004, 64'd0, 5'd13, 0, 1, 64'h89AB_CDEF_0000_0000,
               64'h3004, 8'hF0, 64'd0, 64'h89AB_CDEF);
        mem_op(LOAD, 3'b101, 64'h1002, 64'd0, 5'd14, 1, 1, 64'h0000_0000_F00D_0000,
               64'h1002, 8'h0C, 64'd0, 64'hF00D);
        mem_op(LOAD, 3'b001, 64'h1002, 64'd0, 5'd15, 0, 0, 64'h0000_0000_F00D_0000,
               64'h1002, 8'h0C, 64'd0, 64'hFFFF_FFFF_FFFF_F00D);
        mem_op(LOAD, 3'b011, 64'h4000, 64'd0, 5'd16, 0, 0, 64'h0123_4567_89AB_CDEF,
               64'h4000, 8'hFF, 64'd0, 64'h0123_4567_89AB_CDEF);
        mem_op(STORE, 3'b011, 64'h5000, 64'hDEAD_BEEF_0102_0304, 5'd2, 2, 0, 64'd0,
               64'h5000, 8'hFF, 64'hDEAD_BEEF_0102_0304, 64'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        begin
            wb_exp_t w;
            step();
            drive_op(LOAD, 3'b011, 64'h1004, 64'd0, 5'd9);
            w = '{rd: 5'd0, data: 64'd0, pc: pc, instr: instruction, fault: 1'b1, chk_data: 1'b0};
            wbq.push_back(w);
            @(negedge clk);
            chk("mis_hit", 64'(hit), 64'd1);
            chk("mis_no_req", 64'(dreq_valid), 64'd0);
            step();
            bubble();
            @(negedge clk);
            chk("mis_fault", 64'(wb_fault), 64'd1);
            chk("mis_still_no_req", 64'(dreq_valid), 64'd0);
        end
`else
        mem_op(LOAD, 3'b011, 64'h1004, 64'd0, 5'd9, 0, 0, 64'h1122_3344_5566_7788,
               64'h1000, 8'hFF, 64'd0, 64'h1122_3344_5566_7788);
        mem_op(STORE, 3'b010, 64'h2002, 64'hCAFE_BABE, 5'd4, 0, 0, 64'd0,
               64'h2000, 8'h0F, 64'h0000_0000_CAFE_BABE, 64'd0);
        chk("nomis_fault", 64'(wb_fault), 64'd0);
`endif

        // Reset while a load is outstanding, then a stale response.
        step();
        drive_op(LOAD, 3'b000, 64'h1003, 64'd0, 5'd20);
        begin
            req_exp_t q;
            q = '{addr: 64'h1003, we: 1'b0, wdata: 64'd0, wstrb: 8'h08};
            reqq.push_back(q);
        end
        @(negedge clk);
        step();
        dreq_ready = 1'b1;
        @(negedge clk);
        step();
        dreq_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst2_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst2_wb_data", wb_data, 64'd0);
        chk("rst2_wb_pc", wb_pc, 64'd0);
        chk("rst2_wb_instr", 64'(wb_instruction), 64'd0);
        chk("rst2_wb_fault", 64'(wb_fault), 64'd0);
        chk("rst2_dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst2_dreq_we", 64'(dreq_we), 64'd0);
        chk("rst2_dreq_wstrb", 64'(dreq_wstrb), 64'd0);
        step();
        rst_n = 1'b1;
        bubble();
        @(negedge clk);
        chk("rst2_idle_hit", 64'(hit), 64'd1);
        step();
        drsp_valid = 1'b1;
        drsp_rdata = 64'h0000_0000_8000_0000;
        @(negedge clk);
        chk("stale_rsp_hit", 64'(hit), 64'd1);
        chk("stale_rsp_no_req", 64'(dreq_valid), 64'd0);
        step();
        drsp_valid = 1'b0;
        @(negedge clk);
        chk("stale_rsp_no_wb", 64'(wb_valid), 64'd0);
        step();
        @(negedge clk);

        chk("wbq_drained", 64'(wbq.size()), 64'd0);
        chk("reqq_drained", 64'(reqq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
